// File: rtl/pixel_vram_writer_pkg.sv
// Shared types and packing constants for the pixel-to-VRAM write path.
// Holds the controller state encoding and the per-mode pixel packing rules.
package pixel_vram_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int SHIFT_4BPP = 2;
    localparam int SHIFT_8BPP = 1;

    localparam logic [3:0] MASK_4BPP_MSB = 4'b1000;
    localparam logic [3:0] MASK_8BPP_HI  = 4'b1100;
    localparam logic [3:0] MASK_8BPP_LO  = 4'b0011;

    // Leftmost pixel of a word lives in the most significant nibble/byte.
    function automatic logic [3:0] pixel_mask(input logic bpp8, input logic [1:0] x_lo);
        if (bpp8) begin
            return x_lo[0] ? MASK_8BPP_LO : MASK_8BPP_HI;
        end
        return MASK_4BPP_MSB >> x_lo;
    endfunction

endpackage

// File: rtl/pixel_vram_writer_if.sv
// VRAM write-request channel: request held stable until the memory side acks.
interface pixel_vram_writer_if #(
    parameter int ADDRW = 16
);
    logic             wr;
    logic [ADDRW-1:0] addr;
    logic [15:0]      data;
    logic [3:0]       mask;
    logic             ack;

    modport master (output wr, addr, data, mask, input ack);
    modport slave  (input wr, addr, data, mask, output ack);
endinterface

// File: rtl/pixel_write_fifo.sv
// Small synchronous FIFO for merged VRAM write requests; head is shown combinationally.
module pixel_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pixel_vram_writer.sv
// Packs clipped rasterizer pixels into VRAM words, merging neighbours that share a word.
// state  | meaning
// IDLE   | waiting for start_i, config sampled on start
// ACTIVE | accepting pixels while oe_o is high
// FLUSH  | pipeline settles, accumulator pushed to the FIFO
// DRAIN  | waiting for the FIFO to empty through VRAM acks
// DONE   | one-cycle completion pulse
module pixel_vram_writer
    import pixel_vram_writer_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int ADDRW      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    bpp8_i,
    input  logic [ADDRW-1:0]        base_i,
    input  logic [ADDRW-1:0]        line_words_i,
    input  logic signed [CORDW-1:0] width_i,
    input  logic signed [CORDW-1:0] height_i,
    input  logic [7:0]              color_i,
    input  logic                    start_i,
    input  logic signed [CORDW-1:0] x_i,
    input  logic signed [CORDW-1:0] y_i,
    input  logic                    drawing_i,
    input  logic                    shape_done_i,
    output logic                    oe_o,
    pixel_vram_writer_if.master     vram,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = ADDRW + 4;

    state_t state, state_nxt;

    logic                    bpp8_r;
    logic [ADDRW-1:0]        base_r, lw_r;
    logic signed [CORDW-1:0] width_r, height_r;
    logic [15:0]             data_r;

    logic             s1_valid;
    logic [ADDRW-1:0] s1_addr;
    logic [3:0]       s1_mask;
    logic             acc_valid;
    logic [ADDRW-1:0] acc_addr;
    logic [3:0]       acc_mask;

    logic          fifo_push, fifo_empty, fifo_full;
    logic [FW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;

    logic                     accept, in_clip;
    logic [CORDW+ADDRW-1:0]   y_prod;
    logic [CORDW-1:0]         x_word;
    logic [ADDRW-1:0]         pix_addr;
    logic                     acc_load, acc_merge, acc_clear;

    // Two slots of headroom cover the pixels still in stage 1 and the accumulator.
    assign oe_o   = (state == ST_ACTIVE) && (fifo_count <= CW'(FIFO_DEPTH - 2));
    assign accept = (state == ST_ACTIVE) && drawing_i && oe_o;
    assign in_clip = !x_i[CORDW-1] && !y_i[CORDW-1] && (x_i < width_r) && (y_i < height_r);

    always_comb begin
        y_prod   = (CORDW+ADDRW)'($unsigned(y_i)) * (CORDW+ADDRW)'(lw_r);
        x_word   = bpp8_r ? ($unsigned(x_i) >> SHIFT_8BPP) : ($unsigned(x_i) >> SHIFT_4BPP);
        pix_addr = base_r + y_prod[ADDRW-1:0] + ADDRW'(x_word);
    end

    always_comb begin
        acc_load  = 1'b0;
        acc_merge = 1'b0;
        acc_clear = 1'b0;
        fifo_push = 1'b0;
        if (s1_valid) begin
            if (acc_valid && (s1_addr == acc_addr)) begin
                acc_merge = 1'b1;
            end else begin
                fifo_push = acc_valid;
                acc_load  = 1'b1;
            end
        end else if ((state == ST_FLUSH) && acc_valid && !fifo_full) begin
            fifo_push = 1'b1;
            acc_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (shape_done_i) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (!s1_valid && (!acc_valid || !fifo_full)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bpp8_r    <= 1'b0;
            base_r    <= '0;
            lw_r      <= '0;
            width_r   <= '0;
            height_r  <= '0;
            data_r    <= '0;
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_mask   <= '0;
            acc_valid <= 1'b0;
            acc_addr  <= '0;
            acc_mask  <= '0;
        end else begin
            if ((state == ST_IDLE) && start_i) begin
                bpp8_r   <= bpp8_i;
                base_r   <= base_i;
                lw_r     <= line_words_i;
                width_r  <= width_i;
                height_r <= height_i;
                data_r   <= bpp8_i ? {2{color_i}} : {4{color_i[3:0]}};
            end
            s1_valid <= accept && in_clip;
            s1_addr  <= pix_addr;
            s1_mask  <= pixel_mask(bpp8_r, x_i[1:0]);
            if (acc_load) begin
                acc_valid <= 1'b1;
                acc_addr  <= s1_addr;
                acc_mask  <= s1_mask;
            end else if (acc_merge) begin
                acc_mask <= acc_mask | s1_mask;
            end else if (acc_clear) begin
                acc_valid <= 1'b0;
            end
        end
    end

    pixel_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .push      (fifo_push),
        .push_data ({acc_addr, acc_mask}),
        .pop       (vram.wr && vram.ack),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign vram.wr   = !fifo_empty;
    assign vram.addr = fifo_empty ? '0 : fifo_head[FW-1:4];
    assign vram.mask = fifo_empty ? '0 : fifo_head[3:0];
    assign vram.data = fifo_empty ? '0 : data_r;

    assign busy_o = (state != ST_IDLE) && (state != ST_DONE);
    assign done_o = (state == ST_DONE);

endmodule
